// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction constants and load clamp helper for the counters library
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  function automatic logic [63:0] clamp_load(input logic [63:0] v, input logic [63:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction
endpackage

// File: rtl/counter_tick_gen.sv
// counter_tick_gen: divide-by-PRESCALE enable tick (used only when COUNTER_PRESCALE_EN is defined)
// Ports: clk, reset (async, active-high), enable (tick counter runs only while high),
//        clr (synchronous restart of the period), tick (high on every PRESCALE-th enabled cycle).
module counter_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(PRESCALE + 1);
  logic [CW-1:0] cnt;
  assign tick = enable && (cnt == CW'(PRESCALE - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down modulo counter with load, wrap/saturate, tc pulse and sticky ovf
// Ports: clk, reset (async, active-high), enable, up_dn (1=up), load/load_val (clamped to MODULUS-1),
//        clear_ovf, count (registered), tc (one-cycle boundary pulse), ovf (sticky boundary flag).
// Optional: COUNTER_PRESCALE_EN adds parameter PRESCALE and advances only on prescaler ticks.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 10,
  parameter int SATURATE = 0
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam bit SAT = (SATURATE == MODE_SAT);
  logic tick, step, at_top, at_bot, bnd;
  logic [WIDTH-1:0] load_c, up_n, dn_n, count_n;
`ifdef COUNTER_PRESCALE_EN
  counter_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .clr(load),
    .tick(tick)
  );
`else
  assign tick = 1'b1;
`endif
  always_comb begin
    load_c = WIDTH'(clamp_load(64'(load_val), 64'(MAXV)));
    at_top = (count == MAXV);
    at_bot = (count == '0);
    step = enable && tick && !load;
    // boundary event: a step attempted past the end of the range in the current direction
    bnd = step && ((up_dn == DIR_UP) ? at_top : at_bot);
    up_n = at_top ? (SAT ? MAXV : '0) : count + WIDTH'(1);
    dn_n = at_bot ? (SAT ? '0 : MAXV) : count - WIDTH'(1);
    count_n = load ? load_c : step ? ((up_dn == DIR_UP) ? up_n : dn_n) : count;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      count <= count_n;
      tc <= bnd;
      ovf <= bnd | (ovf & ~clear_ovf);
    end
endmodule
